mem_bus_unit: RTL

Memory bus unit between the CPU datapath/controller and the external word-wide memory bus. It takes the per-cycle read/write request derived from the controller's memory-address select, write-enable, and save-opcode/save-mem strobes. It runs a req/ack handshake to memory and stalls the controller FSM while a read is outstanding. Writes are posted through a one-entry write buffer, with read-after-write forwarding.

---
 rtl/mem_bus_unit_pkg.sv | 23 ++
 rtl/mem_write_buffer.sv | 56 +++++
 rtl/mem_bus_unit.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/mem_bus_unit_pkg.sv
// Shared definitions for the memory bus unit: FSM encoding, error word and default sizes.
package mem_bus_defs;

  localparam int DEF_DATA_W  = 16;
  localparam int DEF_ADDR_W  = 16;
  localparam int DEF_TIMEOUT = 255;

  // Returned on an aborted read; sliced down to DATA_W by the user.
  localparam logic [63:0] ERR_DATA = '1;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR_BUS  = 2'd1,
    ST_RD_BUS  = 2'd2,
    ST_RD_DONE = 2'd3
  } bus_state_e;

  // The timeout counter only has to reach TIMEOUT-1 before the abort fires.
  function automatic int cnt_width(input int timeout);
    return (timeout < 2) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/mem_write_buffer.sv
// One-entry posted-write buffer: load when empty, clear on drain/abort, address-match output.
// Contents change one cycle after load/clear; clear has priority over load.
module mem_write_buffer
  import mem_bus_defs::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              clr_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [ADDR_W-1:0] cmp_addr_i,
  output logic              vld_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              hit_o
);

  logic              vld_q,  vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  always_comb begin
    vld_d  = vld_q;
    addr_d = addr_q;
    data_d = data_q;
    if (clr_i) begin
      vld_d = 1'b0;
    end else if (load_i) begin
      vld_d  = 1'b1;
      addr_d = addr_i;
      data_d = data_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld_q  <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign vld_o  = vld_q;
  assign addr_o = addr_q;
  assign data_o = data_q;
  assign hit_o  = vld_q & (addr_q == cmp_addr_i);

endmodule

// File: rtl/mem_bus_unit.sv
// CPU-to-memory bus unit: posted writes with read forwarding, req/ack bus with timeout abort.
// Uncontended bus read returns data two cycles after the request; cpu_stall holds the controller meanwhile.
module mem_bus_unit
  import mem_bus_defs::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              cpu_re,
  input  logic              cpu_we,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              rd_valid,
  output logic              cpu_stall,
  output logic              bus_req,
  output logic              bus_we,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic [DATA_W-1:0] bus_rdata,
  input  logic              bus_ack,
  output logic              bus_err
);

  localparam int                CNT_W    = cnt_width(TIMEOUT);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] ERR_WORD = ERR_DATA[DATA_W-1:0];

  bus_state_e        state_q;
  logic              rd_pend_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              bus_req_q;
  logic              bus_we_q;
  logic [ADDR_W-1:0] bus_addr_q;
  logic [DATA_W-1:0] bus_wdata_q;
  logic [DATA_W-1:0] cpu_rdata_q;
  logic              rd_valid_q;
  logic              bus_err_q;

  logic              wb_vld;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              wb_hit;
  logic              wb_load;
  logic              wb_clr;

  logic rd_req;
  logic in_done;
  logic fwd;
  logic rd_new;
  logic to_hit;

  // A simultaneous read and write is treated as a write only.
  assign rd_req  = cpu_re & ~cpu_we;
  // The held request seen during RD_DONE is the one completing, not a new one.
  assign in_done = (state_q == ST_RD_DONE);
  assign fwd     = rd_req & wb_hit & ~rd_pend_q & ~in_done;
  assign rd_new  = rd_req & ~fwd & ~rd_pend_q & ~in_done;
  assign wb_load = cpu_we & ~wb_vld;
  assign to_hit  = (cnt_q == CNT_LAST);
  assign wb_clr  = (state_q == ST_WR_BUS) & (bus_ack | to_hit);

  assign cpu_stall = (rd_req & ~fwd & ~in_done) | (cpu_we & wb_vld);

  mem_write_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wb_load),
    .clr_i      (wb_clr),
    .addr_i     (cpu_addr),
    .data_i     (cpu_wdata),
    .cmp_addr_i (cpu_addr),
    .vld_o      (wb_vld),
    .addr_o     (wb_addr),
    .data_o     (wb_data),
    .hit_o      (wb_hit)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      rd_pend_q   <= 1'b0;
      rd_addr_q   <= '0;
      cnt_q       <= '0;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
      cpu_rdata_q <= '0;
      rd_valid_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      bus_err_q  <= 1'b0;

      if (fwd) begin
        rd_valid_q  <= 1'b1;
        cpu_rdata_q <= wb_data;
      end

      if (rd_new) begin
        rd_pend_q <= 1'b1;
        rd_addr_q <= cpu_addr;
      end

      unique case (state_q)
        ST_IDLE: begin
          // A buffered write always drains before any pending read is issued.
          if (wb_vld) begin
            state_q     <= ST_WR_BUS;
            bus_req_q   <= 1'b1;
            bus_we_q    <= 1'b1;
            bus_addr_q  <= wb_addr;
            bus_wdata_q <= wb_data;
            cnt_q       <= '0;
          end else if (rd_pend_q || rd_new) begin
            state_q    <= ST_RD_BUS;
            bus_req_q  <= 1'b1;
            bus_we_q   <= 1'b0;
            bus_addr_q <= rd_pend_q ? rd_addr_q : cpu_addr;
            cnt_q      <= '0;
          end
        end

        ST_WR_BUS: begin
          if (bus_ack || to_hit) begin
            state_q   <= ST_IDLE;
            bus_req_q <= 1'b0;
            bus_we_q  <= 1'b0;
            bus_err_q <= ~bus_ack;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RD_BUS: begin
          if (bus_ack) begin
            state_q     <= ST_RD_DONE;
            bus_req_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b1;
            cpu_rdata_q <= bus_rdata;
          end else if (to_hit) begin
            state_q     <= ST_RD_DONE;
            bus_req_q   <= 1'b0;
            rd_pend_q   <= 1'b0;
            rd_valid_q  <= 1'b1;
            cpu_rdata_q <= ERR_WORD;
            bus_err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end

        ST_RD_DONE: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign rd_valid  = rd_valid_q;
  assign bus_err   = bus_err_q;

endmodule
